// File: rtl/sipo_deframer_pkg.sv
`default_nettype none
// ============================================================================
// Package : sipo_pkg
// Brief   : Shared FSM state type and default sizes for the serial deframer.
// Rev     : 1.0 - initial release
// ============================================================================
package sipo_pkg;

  // Default word width and output buffer depth.
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 2;

  // Deframer states: HUNT waits for start-of-frame, SHIFT collects bits.
  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_deframer_if.sv
`default_nettype none
// ============================================================================
// Interface : sipo_deframer_if
// Brief     : Serial input, word output handshake and status of the deframer.
//             The master side drives bits and consumes words; the slave side
//             is the deframer itself.
// Rev       : 1.0 - initial release
// ============================================================================
interface sipo_deframer_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             s_in;
  logic             s_en;
  logic             s_sof;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             clr_err;
  logic             overrun;
  logic             frame_err;
  logic             busy;

  modport master (
    output s_in, s_en, s_sof, out_ready, clr_err,
    input  out_data, out_valid, overrun, frame_err, busy
  );

  modport slave (
    input  s_in, s_en, s_sof, out_ready, clr_err,
    output out_data, out_valid, overrun, frame_err, busy
  );

endinterface : sipo_deframer_if
`default_nettype wire

// File: rtl/sipo_deframer_word_fifo.sv
`default_nettype none
// ============================================================================
// Module : word_fifo
// Brief  : Small FIFO holding assembled words. A push into a full buffer is
//          accepted only when a pop happens on the same edge.
// Rev    : 1.0 - initial release
// ============================================================================
module word_fifo
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Accept pops only when data exists; pushes need room or a concurrent pop.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
    end
    // Power-of-two depth lets the pointers wrap by natural overflow.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage, pointers and occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : word_fifo
`default_nettype wire

// File: rtl/sipo_deframer.sv
`default_nettype none
// ============================================================================
// Module : sipo_deframer
// Brief  : Serial-in parallel-out deframer. Collects MSB-first bits starting
//          at a start-of-frame marker into WIDTH-bit words, buffers them in a
//          FIFO and flags dropped words and mid-word start markers.
// Rev    : 1.0 - initial release
// ============================================================================
module sipo_deframer
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  sipo_deframer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic             load;
  logic             shift_en;
  logic             sof_mid;
  logic [WIDTH-1:0] shift_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             word_done;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  assign pop = bus.out_valid && bus.out_ready;

  // Classify the sampled bit and compute the shifter/count after this edge.
  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    sof_mid  = 1'b0;
    if (bus.s_en) begin
      if (bus.s_sof) begin
        load    = 1'b1;
        sof_mid = (state_q == SHIFT);
      end else if (state_q == SHIFT) begin
        shift_en = 1'b1;
      end
    end
    if (load) begin
      shift_nxt = WIDTH'(bus.s_in);
      cnt_nxt   = CW'(1);
    end else if (shift_en) begin
      shift_nxt = (shift_q << 1) | WIDTH'(bus.s_in);
      cnt_nxt   = cnt_q + CW'(1);
    end else begin
      shift_nxt = shift_q;
      cnt_nxt   = cnt_q;
    end
    word_done = (load || shift_en) && (cnt_nxt == CW'(WIDTH));
  end

  // Next-state logic: a start marker enters SHIFT, a full word returns to HUNT.
  always_comb begin
    state_d = state_q;
    if (word_done) begin
      state_d = HUNT;
    end else if (load) begin
      state_d = SHIFT;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM outputs.
  always_comb begin
    bus.busy = (state_q == SHIFT);
  end

  // Datapath and sticky flag next values; a set on the clearing edge wins.
  always_comb begin
    shift_d     = shift_nxt;
    cnt_d       = word_done ? '0 : cnt_nxt;
    overrun_d   = (word_done && fifo_full && !pop) ||
                  (overrun_q && !bus.clr_err);
    frame_err_d = sof_mid || (frame_err_q && !bus.clr_err);
  end

  // Datapath and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.out_valid = !fifo_empty;

  word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_word_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (word_done),
    .push_data (shift_nxt),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (bus.out_data)
  );

endmodule : sipo_deframer
`default_nettype wire

// File: tb/tb_sipo_deframer.sv
`default_nettype none
// ============================================================================
// Module : tb_sipo_deframer
// Brief  : Self-checking bench for sipo_deframer with a word scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sipo_deframer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [7:0] exp_q [$];

  sipo_deframer_if #(.WIDTH(8)) bus ();

  sipo_deframer #(
    .WIDTH (8),
    .DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one bit for one clock edge.
  task automatic send_bit(input logic b, input logic sof);
    bus.s_en  = 1'b1;
    bus.s_in  = b;
    bus.s_sof = sof;
    @(posedge clk);
    #1;
    bus.s_en  = 1'b0;
    bus.s_sof = 1'b0;
    bus.s_in  = 1'b0;
  endtask

  // Send the top n bits of w, MSB first, optionally framed by s_sof.
  task automatic send_bits(input logic [7:0] w, input int n, input logic sof);
    for (int i = 0; i < n; i++) begin
      send_bit(w[7-i], sof && (i == 0));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    idle(1);
    bus.clr_err = 1'b0;
  endtask

  // Monitor: every accepted word is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got=%0h required=none", bus.out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          bad++;
          $display("FAIL pop_data: got=%0h required=%0h", bus.out_data, e);
        end
      end
    end
  end

  initial begin
    logic [7:0] w;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.s_in = 1'b0; bus.s_en = 1'b0; bus.s_sof = 1'b0;
    bus.out_ready = 1'b1; bus.clr_err = 1'b0;

    // Reset values.
    #3;
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_data", bus.out_data, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Basic word with one-cycle latency.
    w = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i], i == 0);
      if (i == 6) begin
        check("a5_valid_early", bus.out_valid, 0);
        check("a5_busy", bus.busy, 1);
      end
    end
    check("a5_valid", bus.out_valid, 1);
    check("a5_data", bus.out_data, 8'hA5);
    check("a5_busy_done", bus.busy, 0);
    idle(2);

    // Same word with a 3-cycle gap between bits 4 and 5.
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i], i == 0);
      if (i == 3) begin
        idle(3);
        check("gap_busy", bus.busy, 1);
        check("gap_valid", bus.out_valid, 0);
      end
    end
    idle(2);
    check("gap_overrun", bus.overrun, 0);
    check("gap_frame_err", bus.frame_err, 0);

    // Overrun: third word dropped while the consumer stalls.
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_bits(8'h11, 8, 1'b1);
    send_bits(8'h22, 8, 1'b1);
    send_bits(8'h33, 8, 1'b1);
    idle(2);
    check("ovr_set", bus.overrun, 1);
    check("ovr_head_stable", bus.out_data, 8'h11);
    bus.out_ready = 1'b1;
    idle(4);
    check("ovr_drained", bus.out_valid, 0);
    pulse_clr();
    check("ovr_clr", bus.overrun, 0);

    // Push into a full buffer on the same edge as a pop.
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    send_bits(8'h11, 8, 1'b1);
    send_bits(8'h22, 8, 1'b1);
    send_bits(8'h33, 7, 1'b1);
    bus.out_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    check("full_pop_overrun", bus.overrun, 0);
    check("full_pop_valid", bus.out_valid, 1);
    idle(5);
    check("full_pop_drained", bus.out_valid, 0);

    // Mid-word start marker discards the partial word.
    exp_q.push_back(8'h3C);
    send_bits(8'hF0, 4, 1'b1);
    send_bits(8'h3C, 8, 1'b1);
    idle(3);
    check("ferr_set", bus.frame_err, 1);
    check("ferr_no_overrun", bus.overrun, 0);
    pulse_clr();
    check("ferr_clr", bus.frame_err, 0);

    // Clear on the same edge as a new frame error: set wins.
    w = 8'h5A;
    exp_q.push_back(8'h5A);
    send_bits(8'hC0, 2, 1'b1);
    bus.clr_err = 1'b1;
    send_bit(w[7], 1'b1);
    bus.clr_err = 1'b0;
    check("ferr_set_wins", bus.frame_err, 1);
    for (int i = 1; i < 8; i++) begin
      send_bit(w[7-i], 1'b0);
    end
    idle(3);
    pulse_clr();
    check("ferr_clr2", bus.frame_err, 0);

    // Reset mid-word with a buffered word; no output after release without sof.
    bus.out_ready = 1'b0;
    send_bits(8'h5A, 8, 1'b1);
    idle(1);
    check("prerst_valid", bus.out_valid, 1);
    send_bits(8'hFF, 5, 1'b1);
    check("prerst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_data", bus.out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_bits(8'hFF, 3, 1'b0);
    send_bits(8'h00, 5, 1'b0);
    idle(3);
    check("post_rst_valid", bus.out_valid, 0);
    check("post_rst_busy", bus.busy, 0);

    // Scoreboard must drain within a bounded time.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      idle(1);
    end
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sipo_deframer
`default_nettype wire

// File: doc/sipo_deframer.md
SIPO_DEFRAMER -- requirements
Module: sipo_deframer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: WIDTH, 8, bits per word.
REQ-003 Parameter: DEPTH, 2, output buffer entries (power of two, >= 2).
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 s_in  in  1  serial data bit, MSB first.
REQ-007 s_en  in  1  s_in valid this cycle; bit sampled only when high.
REQ-008 s_sof  in  1  start-of-frame; meaningful only with s_en, marks the MSB of a word.
REQ-009 out_data  out  WIDTH  assembled word at buffer head.
REQ-010 out_valid  out  1  out_data holds an unread word.
REQ-011 out_ready  in  1  consumer accepts the word; pop when out_valid && out_ready.
REQ-012 clr_err  in  1  synchronous clear of the sticky error flags.
REQ-013 overrun  out  1  sticky: a completed word was dropped because the buffer was full.
REQ-014 frame_err  out  1  sticky: s_sof arrived mid-word.
REQ-015 busy  out  1  high while in SHIFT state.

Function
REQ-016 The FSM SHALL have two states: HUNT (waiting for s_sof) and SHIFT (collecting bits).
REQ-017 In HUNT, s_en without s_sof SHALL be ignored; s_en && s_sof SHALL load s_in as the MSB, set the bit count to 1, and enter SHIFT.
REQ-018 In SHIFT, s_en && !s_sof SHALL shift s_in into the LSB of the shift register and increment the bit count.
REQ-019 In SHIFT, a cycle with s_en low SHALL hold all state; gaps of any length are allowed.
REQ-020 When the bit count reaches WIDTH on an edge, the complete word SHALL be pushed into the buffer on that same edge and the FSM SHALL return to HUNT.
REQ-021 out_valid SHALL rise on the edge after the word's last bit is sampled (latency 1 cycle from last bit to visible word).
REQ-022 In SHIFT, s_en && s_sof SHALL discard the partial word, set frame_err, load s_in as the new MSB, set the count to 1, and stay in SHIFT.
REQ-023 The buffer SHALL be FIFO-ordered; out_data SHALL be stable while out_valid is high and out_ready is low.
REQ-024 If a word completes while the buffer is full and no pop occurs that edge, the word SHALL be dropped, overrun set, and buffer contents left unchanged.
REQ-025 If a word completes on the same edge as a pop from a full buffer, the push SHALL succeed and overrun SHALL NOT be set.
REQ-026 Push and pop on the same edge with a non-empty buffer SHALL leave the occupancy unchanged.
REQ-027 clr_err SHALL clear both flags on the next edge; a set condition on that same edge SHALL win (flag stays set).
REQ-028 The bit counter SHALL be clog2(WIDTH)+1 bits wide; pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously enter HUNT, with the count 0, the buffer empty, and the shift register 0.
REQ-030 During reset, out_valid, overrun, frame_err and busy SHALL be 0 and out_data SHALL be 0.
REQ-031 A reset asserted mid-word SHALL discard the partial word; after release, the block SHALL require a new s_sof.

Structure
REQ-032 Package sipo_pkg SHALL hold the FSM state enum (HUNT, SHIFT) and the default WIDTH/DEPTH constants.
REQ-033 The output buffer SHALL be a separate sub-module, word_fifo (push, pop, full, empty, head data), with the same clk/rst_n.

Verification
REQ-034 Reset, then s_sof+s_en with bits 1,0,1,0,0,1,0,1 on consecutive cycles -> out_valid high one cycle after the 8th bit, out_data=8'hA5.
REQ-035 Same word with s_en low for 3 cycles between bits 4 and 5 -> out_data=8'hA5 and no error flags set.
REQ-036 Hold out_ready low and send 3 words 8'h11, 8'h22, 8'h33 -> overrun=1; the pops then return 8'h11 then 8'h22 only.
REQ-037 Buffer full with out_ready high on the 8th bit of 8'h33 -> no overrun; the pops return 8'h11, 8'h22, 8'h33.
REQ-038 Send 4 bits, then s_sof followed by the word 8'h3C -> frame_err=1 and the only word output is 8'h3C; clr_err pulse -> frame_err=0.
REQ-039 Assert rst_n low after 5 bits -> busy=0 and out_valid=0 immediately; bits sent without s_sof after release -> no output.
